// File: rtl/alu_pkg.sv
// Shared ALU issue definitions.
// Strobe bundle and RV32IM OP/OP-IMM field encodings.
package alu_pkg;

  typedef struct packed {
    logic add;
    logic sub;
    logic mul;
    logic mulh;
    logic mulhsu;
    logic mulhu;
    logic and_op;
    logic or_op;
    logic xor_op;
    logic sll;
    logic srl;
    logic sra;
    logic slt;
    logic sltu;
  } alu_sel_t;

  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_decode.sv
// OP/OP-IMM funct decode into one-hot ALU strobes.
// Anything outside the supported set flags illegal.
import alu_pkg::*;

module alu_decode (
  input  logic       is_imm,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_sel_t   sel,
  output logic       illegal
);

  localparam logic [1:0] K_BASE = {F7_BASE[5], F7_BASE[0]};
  localparam logic [1:0] K_ALT  = {F7_ALT[5], F7_ALT[0]};
  localparam logic [1:0] K_MD   = {F7_MULDIV[5], F7_MULDIV[0]};

  logic [1:0] f7_key;
  logic       row_base;
  logic       row_alt;
  logic       row_md;
  logic       unused_f7;

  assign f7_key    = {funct7[5], funct7[0]};
  assign unused_f7 = ^{funct7[6], funct7[4:1]};

  // OP-IMM shares the base row; funct7 there is immediate bits
  assign row_base = is_imm || (f7_key == K_BASE);
  assign row_alt  = !is_imm && (f7_key == K_ALT);
  assign row_md   = !is_imm && (f7_key == K_MD);

  always_comb begin
    sel     = '0;
    illegal = 1'b0;
    unique case (1'b1)
      row_base: begin
        unique case (funct3)
          F3_ADD:  sel.add    = 1'b1;
          F3_SLL:  sel.sll    = 1'b1;
          F3_SLT:  sel.slt    = 1'b1;
          F3_SLTU: sel.sltu   = 1'b1;
          F3_XOR:  sel.xor_op = 1'b1;
          F3_SR: begin
            if (is_imm && funct7[5]) sel.sra = 1'b1;
            else                     sel.srl = 1'b1;
          end
          F3_OR:   sel.or_op  = 1'b1;
          F3_AND:  sel.and_op = 1'b1;
        endcase
      end
      row_alt: begin
        case (funct3)
          F3_ADD:  sel.sub = 1'b1;
          F3_SR:   sel.sra = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      row_md: begin
        case (funct3)
          F3_MUL:    sel.mul    = 1'b1;
          F3_MULH:   sel.mulh   = 1'b1;
          F3_MULHSU: sel.mulhsu = 1'b1;
          F3_MULHU:  sel.mulhu  = 1'b1;
          default:   illegal    = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX register feeding the ALU.
// Forwarding, decode, valid/ready handshake and flush.
import alu_pkg::*;

module alu_issue_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_imm,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [WIDTH-1:0]  in_rs1_data,
  input  logic [WIDTH-1:0]  in_rs2_data,
  input  logic [WIDTH-1:0]  in_imm,
  input  logic              fwd_mem_we,
  input  logic [REG_AW-1:0] fwd_mem_rd,
  input  logic [WIDTH-1:0]  fwd_mem_data,
  input  logic              fwd_wb_we,
  input  logic [REG_AW-1:0] fwd_wb_rd,
  input  logic [WIDTH-1:0]  fwd_wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_illegal,
  output logic [WIDTH-1:0]  operand_a,
  output logic [WIDTH-1:0]  operand_b,
  output logic              alu_sel_add,
  output logic              alu_sel_sub,
  output logic              alu_sel_mul,
  output logic              alu_sel_mulh,
  output logic              alu_sel_mulhsu,
  output logic              alu_sel_mulhu,
  output logic              alu_sel_and,
  output logic              alu_sel_or,
  output logic              alu_sel_xor,
  output logic              alu_sel_sll,
  output logic              alu_sel_srl,
  output logic              alu_sel_sra,
  output logic              alu_sel_slt,
  output logic              alu_sel_sltu
);

  alu_sel_t         dec_sel;
  logic             dec_illegal;
  alu_sel_t         sel_q;
  logic             valid_q;
  logic             illegal_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_fwd;
  logic [WIDTH-1:0] rs2_fwd;
  logic [WIDTH-1:0] b_raw;
  logic [WIDTH-1:0] b_next;
  logic             is_shift;

  alu_decode u_dec (
    .is_imm  (in_is_imm),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  assign in_ready = !valid_q || out_ready;

  // MEM wins over WB; x0 reads as zero whatever is in flight
  always_comb begin
    a_fwd = in_rs1_data;
    if (in_rs1_addr == '0)
      a_fwd = '0;
    else if (fwd_mem_we && fwd_mem_rd == in_rs1_addr)
      a_fwd = fwd_mem_data;
    else if (fwd_wb_we && fwd_wb_rd == in_rs1_addr)
      a_fwd = fwd_wb_data;
  end

  always_comb begin
    rs2_fwd = in_rs2_data;
    if (in_rs2_addr == '0)
      rs2_fwd = '0;
    else if (fwd_mem_we && fwd_mem_rd == in_rs2_addr)
      rs2_fwd = fwd_mem_data;
    else if (fwd_wb_we && fwd_wb_rd == in_rs2_addr)
      rs2_fwd = fwd_wb_data;
  end

  assign b_raw    = in_is_imm ? in_imm : rs2_fwd;
  assign is_shift = dec_sel.sll || dec_sel.srl || dec_sel.sra;
  assign b_next   = is_shift ?
    {{(WIDTH-5){1'b0}}, b_raw[4:0]} : b_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      sel_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      sel_q     <= '0;
    end else if (in_ready) begin
      valid_q   <= in_valid;
      illegal_q <= in_valid && dec_illegal;
      sel_q     <= in_valid ? dec_sel : '0;
      if (in_valid) begin
        a_q <= a_fwd;
        b_q <= b_next;
      end
    end
  end

  assign out_valid      = valid_q;
  assign out_illegal    = illegal_q;
  assign operand_a      = a_q;
  assign operand_b      = b_q;
  assign alu_sel_add    = sel_q.add;
  assign alu_sel_sub    = sel_q.sub;
  assign alu_sel_mul    = sel_q.mul;
  assign alu_sel_mulh   = sel_q.mulh;
  assign alu_sel_mulhsu = sel_q.mulhsu;
  assign alu_sel_mulhu  = sel_q.mulhu;
  assign alu_sel_and    = sel_q.and_op;
  assign alu_sel_or     = sel_q.or_op;
  assign alu_sel_xor    = sel_q.xor_op;
  assign alu_sel_sll    = sel_q.sll;
  assign alu_sel_srl    = sel_q.srl;
  assign alu_sel_sra    = sel_q.sra;
  assign alu_sel_slt    = sel_q.slt;
  assign alu_sel_sltu   = sel_q.sltu;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed cases plus
// randomized traffic against a behavioural model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_imm = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rs1_addr = '0;
  logic [4:0]  in_rs2_addr = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic [31:0] in_imm = '0;
  logic        fwd_mem_we = 1'b0;
  logic [4:0]  fwd_mem_rd = '0;
  logic [31:0] fwd_mem_data = '0;
  logic        fwd_wb_we = 1'b0;
  logic [4:0]  fwd_wb_rd = '0;
  logic [31:0] fwd_wb_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_illegal;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic s_add, s_sub, s_mul, s_mulh, s_mulhsu, s_mulhu, s_and;
  logic s_or, s_xor, s_sll, s_srl, s_sra, s_slt, s_sltu;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_is_imm      (in_is_imm),
    .in_funct3      (in_funct3),
    .in_funct7      (in_funct7),
    .in_rs1_addr    (in_rs1_addr),
    .in_rs2_addr    (in_rs2_addr),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_imm         (in_imm),
    .fwd_mem_we     (fwd_mem_we),
    .fwd_mem_rd     (fwd_mem_rd),
    .fwd_mem_data   (fwd_mem_data),
    .fwd_wb_we      (fwd_wb_we),
    .fwd_wb_rd      (fwd_wb_rd),
    .fwd_wb_data    (fwd_wb_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_illegal    (out_illegal),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .alu_sel_add    (s_add),
    .alu_sel_sub    (s_sub),
    .alu_sel_mul    (s_mul),
    .alu_sel_mulh   (s_mulh),
    .alu_sel_mulhsu (s_mulhsu),
    .alu_sel_mulhu  (s_mulhu),
    .alu_sel_and    (s_and),
    .alu_sel_or     (s_or),
    .alu_sel_xor    (s_xor),
    .alu_sel_sll    (s_sll),
    .alu_sel_srl    (s_srl),
    .alu_sel_sra    (s_sra),
    .alu_sel_slt    (s_slt),
    .alu_sel_sltu   (s_sltu)
  );

  // op index: 0 add 1 sub 2 mul 3 mulh 4 mulhsu 5 mulhu 6 and
  // 7 or 8 xor 9 sll 10 srl 11 sra 12 slt 13 sltu
  logic [13:0] dut_sel;
  assign dut_sel = {s_sltu, s_slt, s_sra, s_srl, s_sll, s_xor, s_or,
                    s_and, s_mulhu, s_mulhsu, s_mulh, s_mul, s_sub, s_add};

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int base_tab [8] = '{0, 9, 12, 13, 8, 10, 7, 6};

  function automatic int ref_op(logic imm, logic [2:0] f3, logic [6:0] f7);
    if (imm) return (f3 == 3'd5 && f7[5]) ? 11 : base_tab[f3];
    case ({f7[5], f7[0]})
      2'b00: return base_tab[f3];
      2'b10: return (f3 == 3'd0) ? 1 : (f3 == 3'd5) ? 11 : -1;
      2'b01: return (f3 < 3'd4) ? 2 + int'(f3) : -1;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] ref_src(logic [4:0] addr, logic [31:0] rf);
    if (addr == 0) return 32'd0;
    if (fwd_mem_we && fwd_mem_rd == addr) return fwd_mem_data;
    if (fwd_wb_we && fwd_wb_rd == addr) return fwd_wb_data;
    return rf;
  endfunction

  logic        m_valid = 1'b0;
  logic        m_ill = 1'b0;
  int          m_op = -1;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  always @(posedge clk or negedge rst_n) begin : mdl
    int op;
    logic [31:0] b;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_ill   <= 1'b0;
      m_op    <= -1;
      m_a     <= '0;
      m_b     <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_ill   <= 1'b0;
    end else if (!m_valid || out_ready) begin
      m_valid <= in_valid;
      m_ill   <= 1'b0;
      if (in_valid) begin
        op = ref_op(in_is_imm, in_funct3, in_funct7);
        b  = in_is_imm ? in_imm : ref_src(in_rs2_addr, in_rs2_data);
        if (op >= 9 && op <= 11) b = b % 32;
        m_op  <= op;
        m_ill <= (op < 0);
        m_a   <= ref_src(in_rs1_addr, in_rs1_data);
        m_b   <= b;
      end
    end
  end

  always @(posedge clk) begin : cmp
    logic [13:0] es;
    #1;
    es = '0;
    if (m_valid && !m_ill) es[m_op] = 1'b1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("out_illegal", 32'(out_illegal), 32'(m_ill));
    chk("sel_vec", 32'(dut_sel), 32'(es));
    if (m_valid) begin
      chk("operand_a", operand_a, m_a);
      chk("operand_b", operand_b, m_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(logic v, logic imm, logic [2:0] f3, logic [6:0] f7,
                       logic [4:0] r1, logic [4:0] r2,
                       logic [31:0] d1, logic [31:0] d2, logic [31:0] im);
    in_valid    = v;
    in_is_imm   = imm;
    in_funct3   = f3;
    in_funct7   = f7;
    in_rs1_addr = r1;
    in_rs2_addr = r2;
    in_rs1_data = d1;
    in_rs2_data = d2;
    in_imm      = im;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  logic [6:0] f7_pick [5] = '{7'h00, 7'h20, 7'h01, 7'h21, 7'h7f};

  initial begin
    // 1: reset then add, reset during hold
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    drive(1, 0, 3'b000, 7'h00, 5'd1, 5'd2, 32'd5, 32'd7, 0);
    after_edge();
    chk("add_valid", 32'(out_valid), 1);
    chk("add_sel", 32'(s_add), 1);
    chk("add_a", operand_a, 32'd5);
    chk("add_b", operand_b, 32'd7);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    after_edge();
    chk("hold_valid", 32'(out_valid), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_a", operand_a, 0);
    chk("midrst_b", operand_b, 0);
    chk("midrst_sel", 32'(dut_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // 2: forwarding priority and x0
    @(negedge clk);
    fwd_mem_we = 1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hAAAA;
    fwd_wb_we = 1;  fwd_wb_rd = 5'd3;  fwd_wb_data = 32'hBBBB;
    drive(1, 0, 3'b000, 7'h00, 5'd3, 5'd0, 32'h1234, 0, 0);
    after_edge();
    chk("fwd_mem", operand_a, 32'hAAAA);
    @(negedge clk);
    fwd_mem_we = 0;
    after_edge();
    chk("fwd_wb", operand_a, 32'hBBBB);
    @(negedge clk);
    fwd_mem_we = 1; fwd_mem_rd = 0; fwd_wb_rd = 0;
    drive(1, 0, 3'b000, 7'h00, 5'd0, 5'd0, 32'h55, 0, 0);
    after_edge();
    chk("fwd_x0", operand_a, 0);
    @(negedge clk);
    fwd_mem_we = 0; fwd_wb_we = 0;

    // 3: stall
    drive(1, 0, 3'b000, 7'h00, 5'd1, 5'd2, 32'd11, 32'd0, 0);
    after_edge();
    chk("stall_x", operand_a, 32'd11);
    @(negedge clk);
    out_ready = 1'b0;
    drive(1, 0, 3'b000, 7'h20, 5'd1, 5'd2, 32'd22, 32'd1, 0);
    repeat (3) begin
      after_edge();
      chk("stall_a", operand_a, 32'd11);
      chk("stall_ready", 32'(in_ready), 0);
      chk("stall_add", 32'(s_add), 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    after_edge();
    chk("rel_a", operand_a, 32'd22);
    chk("rel_sub", 32'(s_sub), 1);
    @(negedge clk);
    in_valid = 1'b0;
    after_edge();
    chk("drain_valid", 32'(out_valid), 0);

    // 4: flush while holding
    @(negedge clk);
    drive(1, 0, 3'b000, 7'h00, 5'd1, 5'd2, 32'd1, 32'd2, 0);
    after_edge();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1, 0, 3'b000, 7'h20, 5'd1, 5'd2, 32'd9, 32'd3, 0);
    flush = 1'b1;
    after_edge();
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_sel", 32'(dut_sel), 0);
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1, 0, 3'b100, 7'h00, 5'd1, 5'd2, 32'hF0, 32'h0F, 0);
    after_edge();
    chk("post_xor", 32'(s_xor), 1);
    chk("post_a", operand_a, 32'hF0);

    // 5: shift masking
    @(negedge clk);
    drive(1, 1, 3'b101, 7'h21, 5'd1, 5'd0, 32'd7, 0, 32'h0000_0423);
    after_edge();
    chk("srai_sel", 32'(s_sra), 1);
    chk("srai_b", operand_b, 32'd3);
    @(negedge clk);
    drive(1, 0, 3'b001, 7'h00, 5'd1, 5'd2, 32'd7, 32'hFFFF_FFE1, 0);
    after_edge();
    chk("sll_sel", 32'(s_sll), 1);
    chk("sll_b", operand_b, 32'd1);

    // 6: illegal and OP-IMM funct7 ignored
    @(negedge clk);
    drive(1, 0, 3'b100, 7'h01, 5'd1, 5'd2, 32'd7, 32'd3, 0);
    after_edge();
    chk("div_ill", 32'(out_illegal), 1);
    chk("div_sel", 32'(dut_sel), 0);
    @(negedge clk);
    drive(1, 1, 3'b000, 7'h20, 5'd1, 5'd0, 32'd7, 0, 32'h0000_0401);
    after_edge();
    chk("addi_add", 32'(s_add), 1);
    chk("addi_sub", 32'(s_sub), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      out_ready    = ($urandom_range(0, 9) < 7);
      flush        = ($urandom_range(0, 19) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      in_is_imm    = $urandom_range(0, 1) == 1;
      in_funct3    = 3'($urandom_range(0, 7));
      in_funct7    = f7_pick[$urandom_range(0, 4)];
      in_rs1_addr  = 5'($urandom_range(0, 7));
      in_rs2_addr  = 5'($urandom_range(0, 7));
      in_rs1_data  = $urandom;
      in_rs2_data  = $urandom;
      in_imm       = $urandom;
      fwd_mem_we   = $urandom_range(0, 1) == 1;
      fwd_mem_rd   = 5'($urandom_range(0, 7));
      fwd_mem_data = $urandom;
      fwd_wb_we    = $urandom_range(0, 1) == 1;
      fwd_wb_rd    = 5'($urandom_range(0, 7));
      fwd_wb_data  = $urandom;
    end

    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) after_edge();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
